// File: rtl/noc_output_arbiter_pkg.sv
// Shared types and defaults for the NoC output-channel arbiter.
package noc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam int FLIT_W_DEF  = 8;
  localparam int PKT_LEN_DEF = 4;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/noc_output_arbiter_if.sv
// FIFO-side and downstream-side signals of one router output channel.
interface noc_output_arbiter_if
  import noc_arb_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int FLIT_W = FLIT_W_DEF
);

  logic                     en;
  logic [N_IN-1:0]          fifo_empty;
  logic [N_IN*FLIT_W-1:0]   fifo_data;
  logic [N_IN-1:0]          fifo_rd;
  logic                     out_full;
  logic [FLIT_W-1:0]        out_data;
  logic                     out_valid;
  logic [N_IN-1:0]          grant;
  logic                     busy;
  logic                     err;

  modport master (
    input  en, fifo_empty, fifo_data, out_full,
    output fifo_rd, out_data, out_valid, grant, busy, err
  );

  modport slave (
    output en, fifo_empty, fifo_data, out_full,
    input  fifo_rd, out_data, out_valid, grant, busy, err
  );

endinterface

// File: rtl/noc_output_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] gnt_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   gnt_rot;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[N-1:0];
  assign gnt_rot = req_rot & (~req_rot + N'(1));
  assign gnt_dbl = {gnt_rot, gnt_rot} << ptr;
  assign gnt     = gnt_dbl[2*N-1:N];
  assign valid   = |req;

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole round-robin arbiter sharing one output channel among N_IN FIFOs.
// Optional stall watchdog enabled by defining NOC_ARB_WATCHDOG_EN.
module noc_output_arbiter
  import noc_arb_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int FLIT_W  = FLIT_W_DEF,
  parameter int PKT_LEN = PKT_LEN_DEF,
  parameter int TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst,
  noc_output_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(N_IN);

  arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  gidx_q, gidx_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  src_idx_q, src_idx_d;
  logic [CNT_W-1:0]  flit_cnt_q, flit_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              rd_ok;
  logic [PTR_W-1:0]  next_ptr;
  logic [PTR_W-1:0]  arb_idx;
  logic [N_IN-1:0]   arb_gnt;
  logic              arb_valid;
  logic [FLIT_W-1:0] fifo_word [N_IN];

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_word
      assign fifo_word[gi] = bus.fifo_data[gi*FLIT_W +: FLIT_W];
    end
  endgenerate

  rr_arbiter #(.N(N_IN), .PTR_W(PTR_W)) u_rr (
    .req   (~bus.fifo_empty),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (arb_gnt[i]) arb_idx = PTR_W'(i);
    end
  end

  assign next_ptr = (gidx_q == PTR_W'(N_IN - 1)) ? '0 : gidx_q + PTR_W'(1);

`ifdef NOC_ARB_WATCHDOG_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    flit_cnt_d = flit_cnt_q;
`ifdef NOC_ARB_WATCHDOG_EN
    stall_cnt_d = stall_cnt_q;
    err_d       = 1'b0;
`endif
    rd_ok = (state_q == XFER) && bus.en && !bus.fifo_empty[gidx_q] &&
            !bus.out_full && (flit_cnt_q < CNT_W'(PKT_LEN));
    out_valid_d = rd_ok;
    src_idx_d   = rd_ok ? gidx_q : src_idx_q;

    // en low freezes every transition; only out_valid is allowed to fall.
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            gidx_d     = arb_idx;
            flit_cnt_d = '0;
            state_d    = XFER;
`ifdef NOC_ARB_WATCHDOG_EN
            stall_cnt_d = '0;
`endif
          end
        end
        XFER: begin
          if (rd_ok) begin
            flit_cnt_d = flit_cnt_q + CNT_W'(1);
            if (flit_cnt_q == CNT_W'(PKT_LEN - 1)) state_d = DRAIN;
          end
`ifdef NOC_ARB_WATCHDOG_EN
          // Only an empty source counts as a stall; downstream backpressure does not.
          if (rd_ok) begin
            stall_cnt_d = '0;
          end else if (bus.fifo_empty[gidx_q]) begin
            if (stall_cnt_q == STALL_W'(TIMEOUT - 1)) begin
              err_d       = 1'b1;
              state_d     = IDLE;
              rr_ptr_d    = next_ptr;
              flit_cnt_d  = '0;
              stall_cnt_d = '0;
            end else begin
              stall_cnt_d = stall_cnt_q + STALL_W'(1);
            end
          end
`endif
        end
        DRAIN: begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      src_idx_q   <= '0;
      flit_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      src_idx_q   <= src_idx_d;
      flit_cnt_q  <= flit_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef NOC_ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.fifo_rd   = rd_ok ? (N_IN'(1) << gidx_q) : '0;
  assign bus.grant     = (state_q != IDLE) ? (N_IN'(1) << gidx_q) : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  // FIFO data lands one cycle after the read, alongside the registered valid.
  assign bus.out_data  = out_valid_q ? fifo_word[src_idx_q] : '0;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Scoreboard bench for noc_output_arbiter with behavioural FIFO models.
// Define NOC_ARB_WATCHDOG_EN to also exercise the stall watchdog.
module tb_noc_output_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int PL = 4;
  localparam int TO = 16;

  logic clk = 1'b1;
  logic rst;
  always #5 clk = ~clk;

  noc_output_arbiter_if #(.N_IN(N), .FLIT_W(W)) bus ();

  noc_output_arbiter #(.N_IN(N), .FLIT_W(W), .PKT_LEN(PL), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int port;
    int data;
    bit first;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] fq   [N][$];
  logic [W-1:0] pend [N][$];
  logic [W-1:0] dout [N] = '{default: '0};
  logic [N-1:0] empty_r = '1;
  logic [N-1:0] rd_last = '0;
  int rd_cnt [N] = '{default: 0};
  int cyc = 0, last_rd_cyc = 0, err_cnt = 0, last_valid_cyc = 0;
  bit gap_en = 1'b0, have_prev = 1'b0;
  int n_vec = 0, n_bad = 0;

  assign bus.fifo_empty = empty_r;
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dout
      assign bus.fifo_data[gi*W +: W] = dout[gi];
    end
  endgenerate

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // FIFO models: registered Data_out, pushes become visible after the next edge.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus.fifo_rd[i]) begin
        rd_cnt[i]   <= rd_cnt[i] + 1;
        last_rd_cyc <= cyc;
        if (fq[i].size() > 0) dout[i] <= fq[i].pop_front();
      end
      while (pend[i].size() > 0) fq[i].push_back(pend[i].pop_front());
      empty_r[i] <= (fq[i].size() == 0);
    end
    rd_last <= bus.fifo_rd;
    cyc     <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      exp_t e;
      check_eq("valid_vs_rd", 32'(bus.out_valid), 32'(|rd_last));
      if (|bus.fifo_rd) check_eq("rd_in_grant", 32'(bus.fifo_rd & ~bus.grant), 32'd0);
      if (!bus.en || bus.out_full) check_eq("rd_blocked", 32'(bus.fifo_rd), 32'd0);
      if (bus.err) begin
        err_cnt++;
        check_eq("err_delay", 32'(cyc - last_rd_cyc), 32'(TO + 1));
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_flit", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("flit port=%0d data=0x%02h grant=%b t=%0t", e.port, bus.out_data, bus.grant, $time);
          check_eq("flit_data", 32'(bus.out_data), 32'(e.data));
          check_eq("flit_owner", 32'(bus.grant), 32'(1 << e.port));
          if (gap_en && e.first && have_prev)
            check_eq("pkt_gap", 32'(cyc - last_valid_cyc), 32'd3);
          last_valid_cyc = cyc;
          have_prev      = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int port, input int first, input int n);
    for (int k = 0; k < n; k++) pend[port].push_back(W'(port*16 + first + k));
  endtask

  task automatic expect_flits(input int port, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.port  = port;
      e.data  = port*16 + first + k;
      e.first = (k == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      fq[i].delete();
      pend[i].delete();
      rd_cnt[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_grant"}, 32'(bus.grant), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_data"}, 32'(bus.out_data), 32'd0);
    check_eq({tag, "_rd"}, 32'(bus.fifo_rd), 32'd0);
    check_eq({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    bus.en = 1'b1;
    bus.out_full = 1'b0;
    flush();
    tick();
    tick();
    check_reset_outputs("rst");
    rst = 1'b1;
  endtask

  task automatic wait_sb(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_rd(input int port, input int target, input string tag);
    int n = 0;
    while (rd_cnt[port] < target && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(rd_cnt[port]), 32'(target));
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input string tag);
    int n = 0;
    while (bus.grant !== g && n < 100) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(bus.grant), 32'(g));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at t=%0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b1;
    bus.out_full = 1'b0;
    #1 rst = 1'b0;
    #13 check_reset_outputs("por");
    #2 rst = 1'b1;

    // Single packet from FIFO0.
    tick();
    load(0, 1, 4);
    expect_flits(0, 1, 4);
    wait_grant(4'b0001, "t1_grant");
    wait_sb("t1_done");
    tick();
    check_eq("t1_busy_fall", 32'(bus.busy), 32'd0);
    check_eq("t1_grant_idle", 32'(bus.grant), 32'd0);
    check_eq("t1_fifo0_empty", 32'(empty_r[0]), 32'd1);

    // Round-robin across three loaded FIFOs, two packets each.
    do_reset();
    gap_en = 1'b1;
    have_prev = 1'b0;
    load(0, 0, 8);
    load(1, 0, 8);
    load(2, 0, 8);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 3; p++) expect_flits(p, r*PL, PL);
    wait_sb("t2_done");
    gap_en = 1'b0;

    // Downstream backpressure after the second flit.
    do_reset();
    load(1, 0, 4);
    expect_flits(1, 0, 4);
    wait_rd(1, 2, "t3_rd2");
    bus.out_full = 1'b1;
    repeat (5) tick();
    check_eq("t3_stall_rd", 32'(rd_cnt[1]), 32'd2);
    bus.out_full = 1'b0;
    wait_sb("t3_done");

    // Source runs dry mid-packet while another FIFO waits.
    do_reset();
    load(3, 0, 2);
    expect_flits(3, 0, 4);
    expect_flits(0, 0, 4);
    wait_grant(4'b1000, "t4_grant");
    load(0, 0, 4);
    repeat (6) begin
      tick();
      check_eq("t4_hold", 32'(bus.grant), 32'h8);
    end
    load(3, 2, 2);
    wait_sb("t4_done");

    // Enable drop mid-packet.
    do_reset();
    load(2, 0, 4);
    expect_flits(2, 0, 4);
    wait_rd(2, 2, "t5_rd2");
    bus.en = 1'b0;
    repeat (3) begin
      tick();
      check_eq("t5_frz_grant", 32'(bus.grant), 32'h4);
      check_eq("t5_frz_busy", 32'(bus.busy), 32'd1);
    end
    check_eq("t5_frz_rd", 32'(rd_cnt[2]), 32'd2);
    bus.en = 1'b1;
    wait_sb("t5_done");
    check_eq("t5_rd_total", 32'(rd_cnt[2]), 32'd4);

    // Asynchronous reset mid-packet.
    load(1, 0, 4);
    expect_flits(1, 0, 2);
    wait_rd(1, 2, "t5b_rd2");
    rst = 1'b0;
    #1 check_reset_outputs("t5b_async");
    flush();
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check_eq("t5b_idle", 32'(bus.busy), 32'd0);

`ifdef NOC_ARB_WATCHDOG_EN
    // FIFO2 supplies one flit of four; the watchdog must release it.
    do_reset();
    load(2, 0, 1);
    expect_flits(2, 0, 1);
    expect_flits(3, 0, 4);
    wait_grant(4'b0100, "t6_grant");
    load(3, 0, 4);
    begin
      int n = 0;
      while (bus.err !== 1'b1 && n < 60) begin
        tick();
        n++;
      end
    end
    check_eq("t6_err", 32'(bus.err), 32'd1);
    tick();
    check_eq("t6_err_pulse", 32'(bus.err), 32'd0);
    check_eq("t6_regrant", 32'(bus.grant), 32'h8);
    wait_sb("t6_done");
    check_eq("t6_err_count", 32'(err_cnt), 32'd1);
`else
    check_eq("err_never", 32'(err_cnt), 32'd0);
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Shares one router output channel among N input FIFO_Buffer instances using wormhole-style round-robin arbitration.
- Watches each FIFO's empty flag and drives that FIFO's read strobe. Muxes the granted FIFO's Data_out onto the output.
- Holds a grant until a full packet of PKT_LEN flits has been forwarded. Respects downstream backpressure.

Parameters:
- N_IN, 4, number of requesting input FIFOs (2..8).
- FLIT_W, 8, flit width; matches the FIFO_Buffer data width.
- PKT_LEN, 4, flits per packet (2..15); the grant is locked for this many flits.
- TIMEOUT, 16, watchdog stall limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  global enable; 0 freezes all state and forces rd to 0.
- fifo_empty  in  N_IN  per-input FIFO empty flags.
- fifo_data  in  N_IN*FLIT_W  concatenated FIFO Data_out; port i occupies bits [i*FLIT_W +: FLIT_W].
- fifo_rd  out  N_IN  per-input read strobes (FIFO "read"); one-hot or zero.
- out_full  in  1  downstream almost-full; must assert with at least 1 free slot remaining.
- out_data  out  FLIT_W  forwarded flit.
- out_valid  out  1  out_data valid this cycle; the downstream writes on every valid cycle.
- grant  out  N_IN  current one-hot owner; 0 when idle.
- busy  out  1  high while a packet is locked.
- err  out  1  one-cycle pulse on watchdog abort; tied to 0 when the feature is off.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, grant=0, fifo_rd=0, out_valid=0, out_data=0, busy=0, err=0, rr_ptr=0, flit_cnt=0.
- Round-robin: on leaving a grant, rr_ptr = granted index + 1, mod N_IN. The search starts at rr_ptr. Requester i is pending when fifo_empty[i]=0.
- States:
  - IDLE: if en and any pending, grant the first pending index at or after rr_ptr. Go to XFER, busy=1, flit_cnt=0. The arbitration decision takes one cycle; the first read occurs the next cycle at the earliest.
  - XFER: each cycle with en & !fifo_empty[g] & !out_full & flit_cnt<PKT_LEN, set fifo_rd[g]=1 (combinational) and flit_cnt+=1.
  - When flit_cnt reaches PKT_LEN after a read, go to DRAIN.
  - Stalls (empty or out_full) hold the grant. Other requesters are never interleaved mid-packet.
  - DRAIN: one cycle for the last flit's out_valid. Then grant=0, busy=0, update rr_ptr, go to IDLE.
- Read latency: FIFO data appears 1 cycle after rd.
  - out_valid is registered: out_valid(t+1) = |fifo_rd(t).
  - out_data is registered from fifo_data[g] sampled in cycle t+1, i.e. out_data is valid together with out_valid.
- Throughput: 1 flit/cycle when unstalled.
- Back-to-back packets: IDLE takes 1 cycle, so inter-packet overhead is DRAIN + IDLE = 2 cycles.
- en=0 mid-XFER: hold all state, rd=0, out_valid drops next cycle. Resume exactly where stopped.
- A FIFO that goes empty mid-packet: hold and wait; no flit is lost or duplicated.
- Reset mid-packet: abort immediately; the partial packet is discarded downstream (the router's concern).
- Single requester: re-granted after each packet; rr_ptr wraps correctly.
- flit_cnt width is 4 bits; PKT_LEN is never exceeded.

Optional Feature:
- Macro: NOC_ARB_WATCHDOG_EN.
- Defined: a stall counter runs in XFER. It increments each cycle with fifo_empty[g]=1 and resets to 0 on any read.
  - When it reaches TIMEOUT: pulse err for 1 cycle, release the grant (state→IDLE), advance rr_ptr past g, clear flit_cnt.
  - out_full stalls do not count.
- Undefined: no counter; err is tied to 0; the grant waits indefinitely.

Decomposition:
- Package noc_arb_pkg holds:
  - state encoding: IDLE=2'd0, XFER=2'd1, DRAIN=2'd2;
  - FLIT_W default;
  - PKT_LEN default;
  - flit-count width constant.
- Sub-module rr_arbiter: combinational, inputs req[N_IN] and ptr; outputs one-hot gnt and a valid flag. It is reused by the router switch allocator.

Test Plan:
1. Reset and single packet: assert rst=0 for 15 ns. Load FIFO0 with flits 1,2,3,4. → grant=0001; out_data 1,2,3,4 on 4 consecutive out_valid cycles; busy falls after DRAIN; FIFO0 empty.
2. Round-robin: FIFOs 0,1,2 each hold 8 flits (2 packets). → grant order 0,1,2,0,1,2; each grant forwards exactly 4 flits; no interleaving.
3. Backpressure: during FIFO1 packet, assert out_full for 5 cycles after flit 2. → rd=0 and out_valid=0 during the stall; flits 3,4 then follow in order; no loss or duplication.
4. Empty mid-packet: FIFO3 holds 2 flits, and 2 more are written 6 cycles later. → grant stays 1000 throughout; other pending FIFOs are not served until flit 4 is forwarded.
5. Enable and reset mid-operation: drop en for 3 cycles mid-packet → state frozen, resumes at the correct flit. Then assert rst mid-packet → all outputs are 0 asynchronously.
6. With NOC_ARB_WATCHDOG_EN and TIMEOUT=16: FIFO2 supplies 1 of 4 flits. → err pulses 17 cycles after the last read; grant moves to the next pending FIFO.
